// File: rtl/rv_pkg.sv
// Values shared by the decode, hazard and register-file logic of the RV32I core.
package rv_pkg;
   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int ZERO_REG      = 0;
endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bundle of the multi-port register file.
interface reg_file_mp_if
   import rv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic                 we;
   logic [AW-1:0]        waddr;
   logic [XLEN-1:0]      wdata;
   logic [NRD*AW-1:0]    ra;
   logic [NRD*XLEN-1:0]  rd;
   logic [NRD-1:0]       rd_busy;
   logic                 issue_valid;
   logic [AW-1:0]        issue_rd;
   logic                 any_busy;

   modport master (
      output we, waddr, wdata, ra, issue_valid, issue_rd,
      input  rd, rd_busy, any_busy
   );

   modport slave (
      input  we, waddr, wdata, ra, issue_valid, issue_rd,
      output rd, rd_busy, any_busy
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, set wins on a same-register collision.
module reg_scoreboard
   import rv_pkg::*;
#(
   parameter int NREGS = NREGS_DEFAULT,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   output logic [NREGS-1:0] busy,
   output logic             any_busy
);
   logic [NREGS-1:0] busy_next;

   // Clear is applied before set so a newer producer to the same register survives.
   always_comb begin
      busy_next = busy;
      if (clr_en && (clr_addr != AW'(ZERO_REG))) busy_next[clr_addr] = 1'b0;
      if (set_en && (set_addr != AW'(ZERO_REG))) busy_next[set_addr] = 1'b1;
      busy_next[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_next;
   end

   assign any_busy = |busy;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with write-first bypass and RAW busy scoreboard.
module reg_file_mp
   import rv_pkg::*;
#(
   parameter int  XLEN  = XLEN_DEFAULT,
   parameter int  NREGS = NREGS_DEFAULT,
   parameter int  NRD   = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input logic           clk,
   input logic           rst,
   reg_file_mp_if.slave  bus
);
   logic [XLEN-1:0]     regs [NREGS];
   logic [NREGS-1:0]    busy;
   logic                any_busy;
   logic                wr_en;
   logic [NRD*XLEN-1:0] rd_flat;
   logic [NRD-1:0]      busy_flat;

   assign wr_en = bus.we && (bus.waddr != AW'(ZERO_REG));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      end else if (wr_en) begin
         regs[bus.waddr] <= bus.wdata;
      end
   end

   reg_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (bus.issue_valid),
      .set_addr (bus.issue_rd),
      .clr_en   (bus.we),
      .clr_addr (bus.waddr),
      .busy     (busy),
      .any_busy (any_busy)
   );

   // Bypass is gated by rst so a write presented during reset never leaks to rd.
   for (genvar i = 0; i < NRD; i++) begin : g_port
      logic [AW-1:0] addr;
      logic          nz;
      logic          hit;

      assign addr = bus.ra[i*AW +: AW];
      assign nz   = (addr != AW'(ZERO_REG));
      assign hit  = rst && bus.we && (bus.waddr == addr);
      assign rd_flat[i*XLEN +: XLEN] = (!rst || !nz) ? '0 : (hit ? bus.wdata : regs[addr]);
      assign busy_flat[i] = busy[addr] && !hit && nz;
   end

   assign bus.rd       = rd_flat;
   assign bus.rd_busy  = busy_flat;
   assign bus.any_busy = any_busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: expectations queued at drive time, drained after settling.
module tb_reg_file_mp;
   logic clk;
   logic rst;

   reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();
   reg_file_mp_if #(.XLEN(32), .NREGS(16), .NRD(4)) bus4 ();

   reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   reg_file_mp #(.XLEN(32), .NREGS(16), .NRD(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          kind;   // 0 rd, 1 rd_busy, 2 any_busy, 3 rd of 4-port build
      int          port;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic expect_v(input string tag, input int kind, input int port, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.port = port; e.val = val;
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] sample(input int kind, input int port);
      case (kind)
         0:       return bus.rd[port*32 +: 32];
         1:       return {31'b0, bus.rd_busy[port]};
         2:       return {31'b0, bus.any_busy};
         default: return bus4.rd[port*32 +: 32];
      endcase
   endfunction

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = sample(e.kind, e.port);
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            $error("check %s", e.tag);
         end
      end
   endtask

   task automatic set_ra(input int a0, input int a1);
      bus.ra = {5'(a1), 5'(a0)};
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      bus.we = 1'b1; bus.waddr = 5'(a); bus.wdata = d;
   endtask

   task automatic iss(input int a);
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(a);
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.issue_valid = 1'b0;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.ra = '0;
      bus.issue_valid = 1'b0; bus.issue_rd = '0;
      bus4.we = 1'b0; bus4.waddr = '0; bus4.wdata = '0; bus4.ra = '0;
      bus4.issue_valid = 1'b0; bus4.issue_rd = '0;

      // Held in reset
      edge_step();
      set_ra(5, 31);
      expect_v("rst_rd0", 0, 0, 32'h0);
      expect_v("rst_rd1", 0, 1, 32'h0);
      expect_v("rst_any", 2, 0, 32'h0);
      drain();
      edge_step();
      rst = 1'b1;

      // Reset state across every nonzero register
      for (int a = 1; a < 32; a++) begin
         set_ra(a, 32 - a);
         expect_v("post_rst_rd0", 0, 0, 32'h0);
         expect_v("post_rst_busy0", 1, 0, 32'h0);
         expect_v("post_rst_rd1", 0, 1, 32'h0);
         expect_v("post_rst_any", 2, 0, 32'h0);
         drain();
      end

      // Write with same-cycle bypass, then readback from storage
      edge_step();
      wr(5, 32'hDEADBEEF);
      set_ra(5, 6);
      expect_v("bypass_rd0", 0, 0, 32'hDEADBEEF);
      expect_v("bypass_other_rd1", 0, 1, 32'h0);
      drain();
      edge_step();
      idle();
      expect_v("stored_rd0", 0, 0, 32'hDEADBEEF);
      drain();

      // x0 protection
      wr(0, 32'hFFFFFFFF);
      iss(0);
      set_ra(0, 0);
      expect_v("x0_bypass_rd0", 0, 0, 32'h0);
      expect_v("x0_bypass_rd1", 0, 1, 32'h0);
      expect_v("x0_busy0", 1, 0, 32'h0);
      drain();
      edge_step();
      idle();
      expect_v("x0_rd0", 0, 0, 32'h0);
      expect_v("x0_busy0_after", 1, 0, 32'h0);
      expect_v("x0_busy1_after", 1, 1, 32'h0);
      expect_v("x0_any", 2, 0, 32'h0);
      drain();

      // Scoreboard set, bypassed writeback, clear
      iss(7);
      set_ra(7, 7);
      expect_v("sb_pre_busy0", 1, 0, 32'h0);
      drain();
      edge_step();
      idle();
      expect_v("sb_busy0", 1, 0, 32'h1);
      expect_v("sb_busy1_dup", 1, 1, 32'h1);
      expect_v("sb_any", 2, 0, 32'h1);
      drain();
      wr(7, 32'd9);
      expect_v("sb_wb_busy0", 1, 0, 32'h0);
      expect_v("sb_wb_rd0", 0, 0, 32'd9);
      expect_v("sb_wb_rd1_dup", 0, 1, 32'd9);
      expect_v("sb_wb_any_pending", 2, 0, 32'h1);
      drain();
      edge_step();
      idle();
      expect_v("sb_clr_busy0", 1, 0, 32'h0);
      expect_v("sb_clr_rd0", 0, 0, 32'd9);
      expect_v("sb_clr_any", 2, 0, 32'h0);
      drain();

      // Set/clear collision on one register, then on different registers
      iss(3);
      edge_step();
      iss(3);
      wr(3, 32'h33);
      edge_step();
      idle();
      set_ra(3, 8);
      expect_v("coll_busy0", 1, 0, 32'h1);
      expect_v("coll_any", 2, 0, 32'h1);
      expect_v("coll_rd0", 0, 0, 32'h33);
      drain();
      iss(8);
      wr(3, 32'h44);
      edge_step();
      idle();
      expect_v("split_busy3", 1, 0, 32'h0);
      expect_v("split_rd3", 0, 0, 32'h44);
      expect_v("split_busy8", 1, 1, 32'h1);
      drain();
      wr(8, 32'h1);
      expect_v("split_wb8_busy", 1, 1, 32'h0);
      expect_v("split_wb8_rd", 0, 1, 32'h1);
      drain();
      edge_step();
      idle();
      expect_v("split_any", 2, 0, 32'h0);
      drain();

      // Asynchronous reset between edges
      iss(4);
      wr(4, 32'h55);
      edge_step();
      idle();
      set_ra(4, 9);
      expect_v("pre_arst_rd0", 0, 0, 32'h55);
      expect_v("pre_arst_busy0", 1, 0, 32'h1);
      expect_v("pre_arst_any", 2, 0, 32'h1);
      drain();
      rst = 1'b0;
      wr(9, 32'hAA);
      iss(9);
      expect_v("arst_rd0", 0, 0, 32'h0);
      expect_v("arst_busy0", 1, 0, 32'h0);
      expect_v("arst_any", 2, 0, 32'h0);
      expect_v("arst_bypass_rd1", 0, 1, 32'h0);
      drain();
      edge_step();
      idle();
      rst = 1'b1;
      expect_v("rel_rd4", 0, 0, 32'h0);
      expect_v("rel_rd9", 0, 1, 32'h0);
      expect_v("rel_busy9", 1, 1, 32'h0);
      expect_v("rel_any", 2, 0, 32'h0);
      drain();
      wr(10, 32'h1234);
      edge_step();
      idle();
      set_ra(10, 4);
      expect_v("first_wr_rd10", 0, 0, 32'h1234);
      drain();

      // Four-port, 16-register build
      for (int k = 0; k < 4; k++) begin
         bus4.we    = 1'b1;
         bus4.waddr = (k == 3) ? 4'd15 : 4'(k + 1);
         bus4.wdata = (k == 3) ? 32'd15 : 32'(k + 1);
         edge_step();
      end
      bus4.we = 1'b0;
      bus4.ra = {4'd15, 4'd3, 4'd2, 4'd1};
      expect_v("p4_rd0", 3, 0, 32'd1);
      expect_v("p4_rd1", 3, 1, 32'd2);
      expect_v("p4_rd2", 3, 2, 32'd3);
      expect_v("p4_rd3", 3, 3, 32'd15);
      drain();
      bus4.ra = {4'd1, 4'd15, 4'd0, 4'd3};
      expect_v("p4_swap_rd0", 3, 0, 32'd3);
      expect_v("p4_swap_rd1", 3, 1, 32'd0);
      expect_v("p4_swap_rd2", 3, 2, 32'd15);
      expect_v("p4_swap_rd3", 3, 3, 32'd1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the pipelined RV32I core, replacing the fixed two-port file in the decode stage. It adds configurable width, depth and read-port count, same-cycle write-to-read bypass, and a per-register busy scoreboard so decode can detect RAW hazards against in-flight writebacks without external comparators. It sits between the decode stage (read and issue side) and the writeback stage (write side).

## Interface
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers; power of two, at least 2.
- NRD, 2: number of independent read ports, 1..4.
- AW, $clog2(NREGS): address width; derived, never overridden.
- clk  in  1  single core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  writeback write enable.
- waddr  in  AW  writeback destination register.
- wdata  in  XLEN  writeback data.
- ra  in  NRD*AW  flattened read addresses; port i is bits [i*AW +: AW].
- rd  out  NRD*XLEN  flattened read data; port i is bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  per-port hazard flag: the addressed register has a pending, unbypassed write.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- any_busy  out  1  OR of all busy bits; used by the fence/drain logic.

## Operation
- Storage: NREGS x XLEN registers. Register 0 reads as 0 always. Writes to register 0 are discarded.
- Write: on a rising edge with we=1 and waddr!=0, reg[waddr] <= wdata.
- Read (combinational, per port i):
  - If ra_i==0, rd_i=0.
  - Else if we=1 and waddr==ra_i, rd_i=wdata (write-first bypass).
  - Else rd_i=reg[ra_i].
- Scoreboard: busy[NREGS] bits; busy[0] is held at 0 permanently.
  - Set: a rising edge with issue_valid=1 and issue_rd!=0 sets busy[issue_rd].
  - Clear: a rising edge with we=1 and waddr!=0 clears busy[waddr].
  - If set and clear hit the same register on the same edge, set wins, because a newer producer is now in flight.
  - Set and clear on different registers both take effect.
- rd_busy_i = busy[ra_i] & ~(we & waddr==ra_i) & (ra_i!=0). A same-cycle bypass resolves the hazard.
- any_busy = |busy.
- Duplicate read addresses across ports are legal; each port returns identical data and busy.

## Timing
- Read latency 0: rd and rd_busy are combinational from ra, we, waddr, wdata and state.
- Write latency 1: data is visible from storage on the cycle after the write edge, and via bypass during the write cycle.
- Scoreboard latency 1: a busy bit set at edge N is visible on rd_busy from cycle N onward.
- Reset (rst=0), asynchronous, with effect regardless of clk:
  - All registers are cleared to 0.
  - All busy bits are cleared.
  - rd=0, rd_busy=0, any_busy=0.
  - While rst=0, writes and issues are ignored.
  - Reset asserted mid-writeback discards the write. The first write after release lands on the first rising edge with rst=1.
- No initial-block preloading; program state comes only from writes.

## Structure
- Shared package rv_pkg holds XLEN_DEFAULT=32, NREGS_DEFAULT=32 and the ZERO_REG=0 constant. The decode and hazard units use the same values.
- One sub-module, reg_scoreboard, contains the busy-bit array, set/clear arbitration and any_busy. Parameters are NREGS and AW; ports are clk, rst, set_en, set_addr, clr_en, clr_addr and busy vector out.
- The top level holds storage, the read muxes, bypass and per-port rd_busy gating, generated over NRD.

## Test plan
- Reset then read: rst=0 then released, read ports 1..31 → all rd=0, rd_busy=0, any_busy=0.
- Write/readback: we=1, waddr=5, wdata=32'hDEADBEEF.
  - Same cycle with ra0=5 → rd0=DEADBEEF via bypass.
  - Next cycle with we=0 → rd0=DEADBEEF from storage.
- x0 protection: we=1, waddr=0, wdata=32'hFFFFFFFF; issue_valid with issue_rd=0 → rd for ra=0 is 0 and busy[0] stays 0 on all ports.
- Scoreboard:
  - issue_rd=7 at edge N → rd_busy=1 for ra=7 from cycle N.
  - Writeback we=1, waddr=7, wdata=9 in cycle M → rd_busy=0 and rd=9 in cycle M. The busy bit is clear after edge M.
- Set/clear collision: busy[3]=1; same edge applies issue_rd=3 and we=1, waddr=3 → busy[3] remains 1 and any_busy=1.
- Async reset mid-operation: busy[4]=1 and reg[4]=0x55; pull rst low between edges → rd=0 and any_busy=0 immediately, without a clock edge. After release, reg[4] reads 0.
- NRD=4, NREGS=16 build: all four ports read distinct registers 1, 2, 3 and 15 after writes of 1, 2, 3 and 15 → each port returns its own value.
